// File: rtl/joypad_pkg.sv
// Shared constants for the NES joypad serializer: button indices, Four Score
// signatures, serial lengths and the per-port reload word builder.
package joypad_pkg;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam int unsigned PAD_BITS = 8;
  localparam int unsigned SER_BITS = 24;

  localparam logic [7:0]  FS_SIG_P0   = 8'h08;
  localparam logic [7:0]  FS_SIG_P1   = 8'h04;
  localparam logic [15:0] NORMAL_FILL = 16'hFFFF;

  // Normal mode pads the single pad with ones; Four Score chains two pads plus the signature.
  function automatic logic [SER_BITS-1:0] reload_word(input logic                fs,
                                                      input logic [7:0]          sig,
                                                      input logic [PAD_BITS-1:0] hi_pad,
                                                      input logic [PAD_BITS-1:0] lo_pad);
    return fs ? {sig, hi_pad, lo_pad} : {NORMAL_FILL, lo_pad};
  endfunction

endpackage

// File: rtl/joypad_port_shifter.sv
// One NES controller port: 24-bit serial register with level-sensitive strobe
// reload and shift on the falling edge of the port's read clock.
module joypad_port_shifter
  import joypad_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                i_strobe,
  input  logic                i_read,
  input  logic [SER_BITS-1:0] i_reload,
  output logic                o_data
);

  logic [SER_BITS-1:0] sr;
  logic                rd_q;
  logic                rd_fall_c;

  assign rd_fall_c = rd_q & ~i_read;

  // Strobe has priority over a coincident read edge; exhausted data fills with ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr   <= '0;
      rd_q <= 1'b0;
    end else begin
      rd_q <= i_read;
      if (i_strobe) begin
        sr <= i_reload;
      end else if (rd_fall_c) begin
        sr <= {1'b1, sr[SER_BITS-1:1]};
      end
    end
  end

  assign o_data = sr[0];

endmodule

// File: rtl/joypad_serializer.sv
// NES controller-port serializer for up to four pads with per-button autofire
// and optional Four Score multitap mode on $4016/$4017.
module joypad_serializer
  import joypad_pkg::*;
#(
  parameter int unsigned C_ports       = 2,
  parameter int unsigned C_clk_hz      = 21477272,
  parameter int unsigned C_autofire_hz = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_strobe,
  input  logic [1:0]             i_read,
  input  logic [8*C_ports-1:0]   i_buttons,
  input  logic [8*C_ports-1:0]   i_autofire,
  input  logic                   i_fourscore,
  output logic [1:0]             o_data
);

  localparam int unsigned DIV_RAW = C_clk_hz / (2 * C_autofire_hz);
  localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0]       div_cnt;
  logic                   phase;
  logic                   fs;
  logic                   fs_mode_c;
  logic [8*C_ports-1:0]   eff_c;
  logic [3:0][7:0]        pad;
  logic [SER_BITS-1:0]    reload0_c;
  logic [SER_BITS-1:0]    reload1_c;

  // Autofire divider: phase toggles every DIV clocks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (div_cnt == DIV_W'(DIV - 1)) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Mode flag follows i_fourscore only while strobing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fs <= 1'b0;
    end else if (i_strobe) begin
      fs <= i_fourscore;
    end
  end

  assign eff_c = i_buttons & ~(i_autofire & {(8*C_ports){~phase}});

  for (genvar n = 0; n < 4; n++) begin : g_pad
    if (n < C_ports) begin : g_present
      assign pad[n] = eff_c[8*n +: 8];
    end else begin : g_absent
      assign pad[n] = '0;
    end
  end

  assign fs_mode_c = i_strobe ? i_fourscore : fs;
  assign reload0_c = reload_word(fs_mode_c, FS_SIG_P0, pad[2], pad[0]);
  assign reload1_c = reload_word(fs_mode_c, FS_SIG_P1, pad[3], pad[1]);

  joypad_port_shifter u_port0 (
    .clock    (clock),
    .reset    (reset),
    .i_strobe (i_strobe),
    .i_read   (i_read[0]),
    .i_reload (reload0_c),
    .o_data   (o_data[0])
  );

  joypad_port_shifter u_port1 (
    .clock    (clock),
    .reset    (reset),
    .i_strobe (i_strobe),
    .i_read   (i_read[1]),
    .i_reload (reload1_c),
    .o_data   (o_data[1])
  );

endmodule
